// File: rtl/vec_byte_serializer_pkg.sv
// Shared widths, trailer constant and FSM encoding for the word-to-byte serializer.
// The trailer check is a helper function so every consumer agrees on the rule.
package vec_byte_serializer_pkg;

    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 4;
    localparam int WORD_W    = BYTE_W * NUM_BYTES;
    localparam int IDX_W     = 2;
    localparam int CNT_W     = 16;

    localparam logic [1:0] TRAILER = 2'b11;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SEND = 1'b1;

    // True when the packer's fixed trailer bits are not present.
    function automatic logic trailer_bad(input logic [1:0] trl);
        return (trl != TRAILER);
    endfunction

endpackage

// File: rtl/vec_byte_serializer.sv
// Serializes one captured 32-bit word {w,x,y,z} into four output beats, w first,
// flagging a bad trailer on the z byte and counting fully emitted words.
module vec_byte_serializer
    import vec_byte_serializer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BYTE_W-1:0]   w,
    input  logic [BYTE_W-1:0]   x,
    input  logic [BYTE_W-1:0]   y,
    input  logic [BYTE_W-1:0]   z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BYTE_W-1:0]   out_data,
    output logic                out_last,
    output logic                trailer_err,
    output logic [CNT_W-1:0]    word_count
);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [WORD_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_word_count;

    logic                w_out_valid;
    logic                w_last;
    logic                w_out_fire;
    logic                w_in_fire;
    logic                w_in_ready;
    logic [BYTE_W-1:0]   w_byte;

    // Handshake decode; in_ready reaches back through out_ready so a new word can
    // land on the same edge the z byte leaves.
    always_comb begin
        w_out_valid = (r_state == ST_SEND);
        w_last      = w_out_valid && (r_idx == 2'd3);
        w_out_fire  = w_out_valid && out_ready;
        w_in_ready  = (r_state == ST_IDLE) || (w_last && out_ready);
        w_in_fire   = in_valid && w_in_ready;
    end

    // Byte lane select, w occupies the top byte of the held word.
    always_comb begin
        w_byte = {BYTE_W{1'b0}};
        case (r_idx)
            2'd0:    w_byte = r_data[31:24];
            2'd1:    w_byte = r_data[23:16];
            2'd2:    w_byte = r_data[15:8];
            2'd3:    w_byte = r_data[7:0];
            default: w_byte = {BYTE_W{1'b0}};
        endcase
    end

    // FSM, word capture, byte index and emitted-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= 2'd0;
            r_data       <= {WORD_W{1'b0}};
            r_word_count <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_data  <= {w, x, y, z};
                        r_idx   <= 2'd0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_out_fire) begin
                        if (r_idx != 2'd3) begin
                            r_idx <= r_idx + 2'd1;
                        end else begin
                            r_word_count <= r_word_count + 16'd1;
                            r_idx        <= 2'd0;
                            if (w_in_fire) begin
                                r_data <= {w, x, y, z};
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= 2'd0;
                end
            endcase
        end
    end

    // Output drive; everything is forced to zero while no word is held.
    always_comb begin
        in_ready    = w_in_ready;
        out_valid   = w_out_valid;
        word_count  = r_word_count;
        if (w_out_valid) begin
            out_data    = w_byte;
            out_last    = w_last;
            trailer_err = w_last && trailer_bad(r_data[1:0]);
        end else begin
            out_data    = {BYTE_W{1'b0}};
            out_last    = 1'b0;
            trailer_err = 1'b0;
        end
    end

endmodule
